// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//
// MEM-stage data-memory sequencer for the five-stage RISC-V pipeline. It watches
// the EX/MEM register, issues exactly one load or store per instruction over a
// req/ready handshake, and stalls the pipeline while that access is in flight.
// Load data (or zero on timeout) is returned to writeback. A timeout raises a
// one-cycle mem_err pulse.
//
// Parameters
//   TIMEOUT : maximum BUSY cycles to wait for dmem_ready (1 .. 2^CNT_W-1)
//   CNT_W   : timeout counter width
//
// Ports
//   clk, reset                 : clock, asynchronous active-high reset
//   memtoreg_in, memwrite_in   : EX/MEM load flag / lane-aligned store byte mask
//   ALUout_in, rdata2_in       : effective address / lane-aligned store data
//   invalid_in                 : EX/MEM holds a bubble, no access
//   dmem_req/we/addr/wdata     : registered memory request bus
//   dmem_ready, dmem_rdata     : memory completion and read data
//   stall                      : freeze PC, IF/ID, ID/EX and EX/MEM
//   load_data, load_valid      : captured load result for the EX/MEM instruction
//   mem_err                    : one-cycle pulse on access timeout
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memtoreg_in,
    input  logic [3:0]  memwrite_in,
    input  logic [31:0] ALUout_in,
    input  logic [31:0] rdata2_in,
    input  logic        invalid_in,
    output logic        dmem_req,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             is_load_reg;   // access in flight is a pure load
    logic             access;

    // Word addressing drops the byte offset; the lanes are already aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ALUout_in[1:0];

    assign access = !invalid_in && (memtoreg_in || (memwrite_in != 4'd0));

    // Combinational so the pipeline freezes in the same cycle the access shows up.
    assign stall = ((state_reg == IDLE) && access) || (state_reg == BUSY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            is_load_reg <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 4'd0;
            dmem_addr   <= 32'd0;
            dmem_wdata  <= 32'd0;
            load_data   <= 32'd0;
            load_valid  <= 1'b0;
            mem_err     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (access) begin
                        dmem_addr   <= {ALUout_in[31:2], 2'b00};
                        dmem_wdata  <= rdata2_in;
                        // A store wins over a simultaneous load indication.
                        dmem_we     <= memwrite_in;
                        is_load_reg <= memtoreg_in && (memwrite_in == 4'd0);
                        dmem_req    <= 1'b1;
                        cnt_reg     <= '0;
                        state_reg   <= BUSY;
                    end
                end

                BUSY: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    // Ready is checked first so a response in the last allowed
                    // cycle still counts as a success.
                    if (dmem_ready) begin
                        if (is_load_reg) begin
                            load_data <= dmem_rdata;
                        end
                        load_valid <= is_load_reg;
                        dmem_req   <= 1'b0;
                        state_reg  <= DONE;
                    end else if (cnt_reg == CNT_LAST) begin
                        load_data  <= 32'd0;
                        load_valid <= is_load_reg;
                        mem_err    <= 1'b1;
                        dmem_req   <= 1'b0;
                        state_reg  <= DONE;
                    end
                end

                DONE: begin
                    load_valid <= 1'b0;
                    mem_err    <= 1'b0;
                    state_reg  <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
//
// Transaction-level model: each access is described by its kind and the BUSY
// cycle on which memory answers. From that the bench derives the whole cycle
// timeline (detect, min(k,TIMEOUT) request cycles, DONE) and the result, and a
// single negedge process compares the DUT against those expectations.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        memtoreg_in;
    logic [3:0]  memwrite_in;
    logic [31:0] ALUout_in;
    logic [31:0] rdata2_in;
    logic        invalid_in;
    logic        dmem_req;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        mem_err;

    dmem_access_ctrl #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .memtoreg_in(memtoreg_in),
        .memwrite_in(memwrite_in),
        .ALUout_in  (ALUout_in),
        .rdata2_in  (rdata2_in),
        .invalid_in (invalid_in),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected outputs for the current cycle
    logic        chk_en = 1'b0;
    logic        check_bus = 1'b0;
    logic        exp_req, exp_stall, exp_lv, exp_err;
    logic [3:0]  exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_ld;

    // Activity counters used by the literal checks
    int sc = 0, rc = 0, ec = 0;
    int low_run = 0, min_gap = 1000;
    bit seen_req = 0;
    logic [31:0] last_busy_addr = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dmem_req",   {31'd0, dmem_req},   {31'd0, exp_req});
            chk("stall",      {31'd0, stall},      {31'd0, exp_stall});
            chk("load_valid", {31'd0, load_valid}, {31'd0, exp_lv});
            chk("mem_err",    {31'd0, mem_err},    {31'd0, exp_err});
            chk("load_data",  load_data, exp_ld);
            if (check_bus) begin
                chk("dmem_we",    {28'd0, dmem_we}, {28'd0, exp_we});
                chk("dmem_addr",  dmem_addr,  exp_addr);
                chk("dmem_wdata", dmem_wdata, exp_wdata);
            end
            if (stall === 1'b1) sc++;
            if (mem_err === 1'b1) ec++;
            if (dmem_req === 1'b1) begin
                rc++;
                last_busy_addr = dmem_addr;
                if (seen_req && low_run > 0 && low_run < min_gap) min_gap = low_run;
                seen_req = 1;
                low_run = 0;
            end else begin
                low_run++;
            end
        end
    end

    task automatic set_idle(input int kind);
        invalid_in  = (kind == 0);
        memtoreg_in = (kind == 0) ? 1'($urandom) : 1'b0;
        memwrite_in = (kind == 0) ? 4'($urandom) : 4'd0;
        ALUout_in   = $urandom;
        rdata2_in   = $urandom;
        dmem_ready  = 1'($urandom);
        dmem_rdata  = $urandom;
        exp_req = 0; exp_stall = 0; exp_lv = 0; exp_err = 0; check_bus = 0;
    endtask

    task automatic idle_cycle(input int kind);
        @(posedge clk); #1;
        set_idle(kind);
    endtask

    // k = BUSY cycle (1-based) on which memory answers; 0 or >TO means never in time
    task automatic do_access(input logic ld, input logic [3:0] we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int k, input logic [31:0] rd);
        bit is_ld  = ld && (we == 4'd0);
        bit tout   = !(k >= 1 && k <= TO);
        int busy_n = tout ? TO : k;
        @(posedge clk); #1;
        memtoreg_in = ld; memwrite_in = we; ALUout_in = addr; rdata2_in = wdata;
        invalid_in = 0;
        dmem_ready = 1'($urandom); dmem_rdata = $urandom;
        sc = 0; rc = 0; ec = 0;
        exp_req = 0; exp_stall = 1; exp_lv = 0; exp_err = 0; check_bus = 0;
        for (int b = 1; b <= busy_n; b++) begin
            @(posedge clk); #1;
            dmem_ready = (b == k);
            dmem_rdata = (b == k) ? rd : $urandom;
            exp_req = 1; exp_stall = 1; exp_lv = 0; exp_err = 0;
            exp_we = we; exp_addr = {addr[31:2], 2'b00}; exp_wdata = wdata; check_bus = 1;
        end
        @(posedge clk); #1;
        dmem_ready = 1'($urandom); dmem_rdata = $urandom;
        check_bus = 0; exp_req = 0; exp_stall = 0;
        if (tout) exp_ld = 32'd0;
        else if (is_ld) exp_ld = rd;
        exp_lv = is_ld; exp_err = tout;
        $display("txn ld=%0d we=%h addr=%h k=%0d timeout=%0d", ld, we, addr, k, tout);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ld;
        logic [3:0]  we;
        int          k;

        reset = 1; invalid_in = 0; memtoreg_in = 1; memwrite_in = 0;
        ALUout_in = 0; rdata2_in = 0; dmem_ready = 0; dmem_rdata = 0;
        exp_ld = 0; exp_we = 0; exp_addr = 0; exp_wdata = 0;

        // Reset state; stall follows access alone
        @(posedge clk); #1;
        exp_req = 0; exp_stall = 1; exp_lv = 0; exp_err = 0; check_bus = 1; chk_en = 1;
        @(posedge clk); #1;
        invalid_in = 1; exp_stall = 0;
        @(posedge clk); #1;
        reset = 0;
        set_idle(1);

        // Load, single-cycle memory
        do_access(1, 4'd0, 32'h0000_1006, 32'h1111_2222, 1, 32'hDEADBEEF);
        @(negedge clk); #1;
        chk("lit_load_stall_cycles", sc, 2);
        chk("lit_load_addr", last_busy_addr, 32'h0000_1004);
        chk("lit_load_data", load_data, 32'hDEADBEEF);
        chk("lit_load_valid", {31'd0, load_valid}, 32'd1);

        // Store, ready on 4th BUSY cycle (also the timeout cycle: ready wins)
        do_access(0, 4'b1100, 32'h0000_2000, 32'hABCD_0000, 4, 32'h5555_5555);
        @(negedge clk); #1;
        chk("lit_store_stall_cycles", sc, 5);
        chk("lit_store_load_valid", {31'd0, load_valid}, 32'd0);
        chk("lit_store_no_err", ec, 0);

        // Bubble and non-memory instructions
        sc = 0; rc = 0;
        idle_cycle(0); idle_cycle(0); idle_cycle(1); idle_cycle(1);
        @(negedge clk); #1;
        chk("lit_bubble_stall", sc, 0);
        chk("lit_bubble_req", rc, 0);

        // Timeout
        do_access(1, 4'd0, 32'h0000_3008, 32'h0, 0, 32'h0);
        @(negedge clk); #1;
        chk("lit_timeout_req_cycles", rc, 4);
        chk("lit_timeout_err_pulses", ec, 1);
        chk("lit_timeout_load_data", load_data, 32'd0);
        chk("lit_timeout_load_valid", {31'd0, load_valid}, 32'd1);

        // Back-to-back load then store
        idle_cycle(1);
        seen_req = 0; min_gap = 1000;
        do_access(1, 4'd0, 32'h0000_4000, 32'h0, 1, 32'h0BAD_F00D);
        do_access(0, 4'b0011, 32'h0000_4004, 32'h0000_1234, 2, 32'h0);
        @(negedge clk); #1;
        chk("lit_b2b_req_gap", min_gap, 2);

        // Randomised traffic
        for (int t = 0; t < 250; t++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) idle_cycle($urandom_range(0, 1));
            ld = 1'($urandom);
            we = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            if (!ld && we == 4'd0) ld = 1;
            k = $urandom_range(0, 6);
            do_access(ld, we, $urandom, $urandom, k, $urandom);
        end

        // Reset mid-BUSY
        idle_cycle(1);
        @(posedge clk); #1;
        memtoreg_in = 1; memwrite_in = 0; invalid_in = 0; ALUout_in = 32'h0000_5004;
        rdata2_in = 0; dmem_ready = 0;
        exp_req = 0; exp_stall = 1; exp_lv = 0; exp_err = 0; check_bus = 0;
        @(posedge clk); #1;
        dmem_ready = 0;
        exp_req = 1; exp_stall = 1;
        @(posedge clk); #1;
        reset = 1; invalid_in = 1;
        #1;
        chk("lit_rst_req", {31'd0, dmem_req}, 32'd0);
        chk("lit_rst_stall", {31'd0, stall}, 32'd0);
        chk("lit_rst_load_valid", {31'd0, load_valid}, 32'd0);
        exp_req = 0; exp_stall = 0; exp_lv = 0; exp_err = 0; exp_ld = 0;
        exp_we = 0; exp_addr = 0; exp_wdata = 0; check_bus = 1;
        @(posedge clk); #1;
        reset = 0;
        set_idle(1);
        do_access(1, 4'd0, 32'h0000_6000, 32'h0, 2, 32'hCAFE_0001);
        @(negedge clk); #1;
        chk("lit_post_rst_load", load_data, 32'hCAFE_0001);
        idle_cycle(1);
        @(negedge clk); #1;
        chk_en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequences data-memory accesses for the MEM stage of the five-stage RISC-V pipeline. It watches the EX/MEM pipeline register outputs, issues one load or store per instruction to a variable-latency data memory using a req/ready handshake, and stalls the pipeline while the access is outstanding. When the access completes it returns load data to the writeback path and reports a timeout error if the memory never responds.

## Interface
- `TIMEOUT`, default 255: maximum number of BUSY cycles to wait for `dmem_ready`. Legal range is 1..2^CNT_W-1.
- `CNT_W`, default 8: width of the timeout counter.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state immediately.
- `memtoreg_in`, in, 1: EX/MEM load indicator.
- `memwrite_in`, in, 4: EX/MEM store byte-lane mask, already lane-aligned; 0 means no store.
- `ALUout_in`, in, 32: effective address.
- `rdata2_in`, in, 32: store data, already lane-aligned.
- `invalid_in`, in, 1: the instruction in EX/MEM is a bubble or invalid; no access.
- `dmem_req`, out, 1: memory request, registered.
- `dmem_we`, out, 4: byte write enables; 0 for a load.
- `dmem_addr`, out, 32: word address `{ALUout_in[31:2],2'b00}`, latched.
- `dmem_wdata`, out, 32: latched store data.
- `dmem_ready`, in, 1: memory completion, sampled only while `dmem_req`=1.
- `dmem_rdata`, in, 32: read data, valid when `dmem_ready`=1.
- `stall`, out, 1: holds PC, IF/ID, ID/EX and EX/MEM.
- `load_data`, out, 32: captured load data.
- `load_valid`, out, 1: `load_data` is valid for the current EX/MEM instruction.
- `mem_err`, out, 1: one-cycle pulse when an access times out.

## Operation
- An access is required when `access = !invalid_in && (memtoreg_in || memwrite_in != 0)`.
- If a load and a store are both indicated, the store wins: `dmem_we`=`memwrite_in` and `load_valid` stays 0.
- The FSM has three states: IDLE, BUSY and DONE.
- **IDLE**
  - If `access`=1: latch address, data and we; set `dmem_req`=1; clear the counter; go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - `dmem_req` is held at 1; address, data and we are stable.
  - The counter increments each cycle.
  - If `dmem_ready`=1: capture `dmem_rdata` into `load_data` (loads only); drop `dmem_req`; go to DONE.
  - Else if the counter equals TIMEOUT-1: drop `dmem_req`; set `load_data`=0; pulse `mem_err`; go to DONE.
- **DONE**
  - `stall`=0, so the pipeline advances at the end of this cycle.
  - `load_valid`=1 for a completed load, 0 otherwise.
  - No new request is issued in DONE; the next state is always IDLE.
- `stall = (state==IDLE && access) || state==BUSY`. This is combinational, so the pipeline freezes in the same cycle the access appears.
- The EX/MEM inputs are ignored outside IDLE, because they are held stable by `stall`.
- Reset values: state=IDLE, counter=0, `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, `load_data`=0, `load_valid`=0, `mem_err`=0.
  - `stall` is then driven purely by `access`.

## Timing
- Minimum access occupies 3 cycles (IDLE detect, BUSY with ready, DONE), giving 2 stall cycles.
- Each additional cycle without ready adds one stall cycle.
- `load_data`, `load_valid` and `mem_err` are registered and change on the edge entering or leaving DONE.
- Back-to-back accesses: after DONE, the next instruction is evaluated in IDLE. There is no request overlap; `dmem_req` is low for at least 2 cycles (DONE and IDLE) between requests.
- `dmem_ready` asserted while `dmem_req`=0 is ignored.
- If `dmem_ready` arrives in the same cycle the counter hits TIMEOUT-1, ready wins and `mem_err` stays 0.
- Reset asserted mid-BUSY: all outputs clear asynchronously, `dmem_req` drops without waiting for the edge, and the FSM returns to IDLE. Any partial store outcome is the memory's responsibility.
- Counter wrap is impossible because the count is bounded by TIMEOUT-1.

## Test plan
- **Load, single-cycle memory.** Stimulus: `memtoreg_in`=1, `ALUout_in`=0x0000_1006, `dmem_ready`=1 on the first BUSY cycle with `dmem_rdata`=0xDEADBEEF. Required: `dmem_addr`=0x0000_1004, `dmem_we`=0; `stall` high for 2 cycles; `load_valid`=1 and `load_data`=0xDEADBEEF in DONE.
- **Store, 4-cycle memory latency.** Stimulus: `memwrite_in`=4'b1100, `rdata2_in`=0xABCD_0000, ready asserted on the 4th BUSY cycle. Required: `dmem_we`=4'b1100 and `dmem_wdata`=0xABCD_0000 stable throughout BUSY; `stall` high for 5 cycles; `load_valid`=0.
- **Bubble and non-memory instructions.** Stimulus: `invalid_in`=1 with `memtoreg_in`=1; then `memtoreg_in`=0 with `memwrite_in`=0. Required: `dmem_req` and `stall` remain 0 throughout.
- **Timeout.** Stimulus: TIMEOUT=4, load with `dmem_ready` held 0. Required: `dmem_req` high for exactly 4 cycles; `mem_err` pulses 1 cycle in DONE; `load_data`=0; `load_valid`=1. Also apply ready and timeout in the same cycle: `mem_err` must be 0.
- **Back-to-back accesses, then reset mid-BUSY.** Stimulus: a load immediately followed by a store. Required: two separate requests with `dmem_req` low for 2 cycles between them. Then assert `reset` mid-BUSY: `dmem_req`, `stall` and `load_valid` go 0 without waiting for a clock edge; after reset, a fresh load completes normally.
